// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART host scheduler
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT,
    S_DECIDE,
    S_RXRD,
    S_RXHOLD,
    S_TXWR
  } state_t;

  localparam int ST_TXRDY = 0;
  localparam int ST_RXRDY = 1;
  localparam int ST_PERR  = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_OVF   = 4;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_DATA = 2'b01;
  localparam logic [1:0] RD_STAT = 2'b10;

  localparam logic [7:0] CFG_RST = 8'h0B;

endpackage

// File: rtl/uart_host_sched_if.sv
// rtl/uart_host_sched_if.sv - requester, RX stream, config and UART-side signal bundle
interface uart_host_sched_if;
  logic       req_a_valid;
  logic [7:0] req_a_data;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [7:0] req_b_data;
  logic       req_b_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       cfg_we;
  logic [7:0] cfg_wdata;
  logic       cfg_ready;
  logic       uart_write;
  logic [1:0] uart_read;
  logic [7:0] uart_out_port;
  logic [7:0] uart_ds;
  logic       uart_int;
  logic [3:0] uart_baud;
  logic       uart_eight;
  logic       uart_p_en;
  logic       uart_ohel;

  modport slave (
    input  req_a_valid, req_a_data, req_b_valid, req_b_data, rx_ready,
    input  cfg_we, cfg_wdata, uart_ds, uart_int,
    output req_a_ready, req_b_ready, rx_valid, rx_data, cfg_ready,
    output uart_write, uart_read, uart_out_port,
    output uart_baud, uart_eight, uart_p_en, uart_ohel
  );

  modport master (
    output req_a_valid, req_a_data, req_b_valid, req_b_data, rx_ready,
    output cfg_we, cfg_wdata, uart_ds, uart_int,
    input  req_a_ready, req_b_ready, rx_valid, rx_data, cfg_ready,
    input  uart_write, uart_read, uart_out_port,
    input  uart_baud, uart_eight, uart_p_en, uart_ohel
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; bit 0 is requester A, bit 1 is B
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (req[ptr_q]) begin
      gnt[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      gnt[~ptr_q] = 1'b1;
    end
    ptr_d = ptr_q;
    // Point at the side that was not granted: A granted -> B next, and vice versa.
    if (advance && (|gnt)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_host_sched.sv
// rtl/uart_host_sched.sv - UART sequencer: status polling, RX drain, round-robin TX; UART_ERR_CNT_EN builds err_cnt
module uart_host_sched
  import uart_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_host_sched_if.slave   bus,
  output logic [ERR_W-1:0]   err_cnt
);

  state_t     state_q, state_d;
  logic [6:0] cfg_q, cfg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [1:0] stat_q, stat_d;
  logic       rx_valid_q, rx_valid_d;
  logic       int_pend_q, int_pend_d;
  logic       tx_shadow_q, tx_shadow_d;
  logic [1:0] gnt;
  logic       req_any;
  logic       in_tx;

  assign req_any = bus.req_a_valid | bus.req_b_valid;
  // Strobes are suppressed while rst is high so nothing reaches the UART in the reset cycle.
  assign in_tx   = (state_q == S_TXWR) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req_b_valid, bus.req_a_valid}),
    .advance (in_tx),
    .gnt     (gnt)
  );

  assign bus.uart_write    = in_tx & (|gnt);
  assign bus.req_a_ready   = in_tx & gnt[0];
  assign bus.req_b_ready   = in_tx & gnt[1];
  assign bus.uart_out_port = gnt[1] ? bus.req_b_data : bus.req_a_data;
  assign bus.uart_read     = rst                  ? RD_NONE :
                             (state_q == S_STAT)  ? RD_STAT :
                             (state_q == S_RXRD)  ? RD_DATA : RD_NONE;

  assign bus.cfg_ready  = (state_q == S_IDLE);
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.uart_baud  = cfg_q[3:0];
  assign bus.uart_eight = cfg_q[4];
  assign bus.uart_p_en  = cfg_q[5];
  assign bus.uart_ohel  = cfg_q[6];

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    stat_d      = stat_q;
    tx_shadow_d = tx_shadow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_we) begin
          cfg_d = bus.cfg_wdata[6:0];
        end else if (int_pend_q || bus.uart_int || (req_any && tx_shadow_q)) begin
          state_d = S_STAT;
        end
      end
      S_STAT: begin
        stat_d      = bus.uart_ds[1:0];
        tx_shadow_d = bus.uart_ds[ST_TXRDY];
        state_d     = S_DECIDE;
      end
      S_DECIDE: begin
        if (stat_q[ST_RXRDY]) begin
          state_d = S_RXRD;
        end else if (stat_q[ST_TXRDY] && req_any) begin
          state_d = S_TXWR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RXRD: begin
        rx_data_d  = bus.uart_ds;
        rx_valid_d = 1'b1;
        state_d    = S_RXHOLD;
      end
      S_RXHOLD: begin
        if (bus.rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = S_STAT;
        end
      end
      S_TXWR: begin
        if (bus.uart_write) begin
          tx_shadow_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new interrupt in the same cycle as STAT entry must survive the clear.
    int_pend_d = bus.uart_int | (int_pend_q & (state_d != S_STAT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= CFG_RST[6:0];
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      stat_q      <= '0;
      int_pend_q  <= 1'b0;
      tx_shadow_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      stat_q      <= stat_d;
      int_pend_q  <= int_pend_d;
      tx_shadow_q <= tx_shadow_d;
    end
  end

`ifdef UART_ERR_CNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == S_STAT) && (err_q != {ERR_W{1'b1}}) &&
        (bus.uart_ds[ST_PERR] | bus.uart_ds[ST_FERR] | bus.uart_ds[ST_OVF])) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_host_sched.sv
// tb/tb_uart_host_sched.sv - self-checking bench for uart_host_sched
module tb_uart_host_sched;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;
  logic [7:0] stat_val;
  logic [7:0] rx_byte;

  uart_host_sched_if bus();

  uart_host_sched #(.ERR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  assign bus.uart_ds = (bus.uart_read == RD_STAT) ? stat_val :
                       (bus.uart_read == RD_DATA) ? rx_byte  : 8'h00;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       first_b;
    logic [7:0] first_byte;
    logic [7:0] second_byte;
  } tx_vec_t;

  tx_vec_t    vecs [7];
  logic [8:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  int         checks = 0;
  int         failures = 0;
  int         stat_reads = 0;
  bit         hold_mode = 1'b0;
  bit         rx_sb_en = 1'b0;
  logic [7:0] exp_err10;
  logic [7:0] exp_err_sat;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    logic [8:0] e;
    logic [7:0] r;
    if (bus.uart_read == RD_STAT) stat_reads++;
    if (bus.uart_write) begin
      chk("wr_rd_excl", 32'(bus.uart_read), 0);
      chk("one_ready", 32'(bus.req_a_ready ^ bus.req_b_ready), 1);
      if (tx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got %0h expected no write", bus.uart_out_port);
      end else begin
        e = tx_exp.pop_front();
        chk("tx_side", 32'(bus.req_b_ready), 32'(e[8]));
        chk("tx_byte", 32'(bus.uart_out_port), 32'(e[7:0]));
      end
    end else begin
      chk("ready_no_write", 32'({bus.req_a_ready, bus.req_b_ready}), 0);
    end
    if (rx_sb_en && bus.rx_valid && bus.rx_ready) begin
      if (rx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got %0h expected no byte", bus.rx_data);
      end else begin
        r = rx_exp.pop_front();
        chk("rx_byte", 32'(bus.rx_data), 32'(r));
      end
    end
  endtask

  task automatic step();
    bit a_acc;
    bit b_acc;
    @(negedge clk);
    mon();
    a_acc = bus.req_a_ready;
    b_acc = bus.req_b_ready;
    @(posedge clk);
    #1;
    if (!hold_mode) begin
      if (a_acc) bus.req_a_valid = 1'b0;
      if (b_acc) bus.req_b_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold_mode = 1'b0;
    rx_sb_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h11, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 8'h33, 8'h44};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 8'h55, 8'h00};
    vecs[4] = '{1'b1, 8'h66, 1'b1, 8'h77, 1'b0, 8'h66, 8'h77};
    vecs[5] = '{1'b1, 8'h88, 1'b0, 8'h00, 1'b0, 8'h88, 8'h00};
    vecs[6] = '{1'b1, 8'h99, 1'b1, 8'hAA, 1'b1, 8'hAA, 8'h99};
`ifdef UART_ERR_CNT_EN
    exp_err10   = 8'd10;
    exp_err_sat = 8'hFF;
`else
    exp_err10   = 8'd0;
    exp_err_sat = 8'd0;
`endif

    bus.req_a_valid = 1'b0;
    bus.req_a_data  = 8'h00;
    bus.req_b_valid = 1'b0;
    bus.req_b_data  = 8'h00;
    bus.rx_ready    = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_wdata   = 8'h00;
    bus.uart_int    = 1'b0;
    stat_val = 8'h00;
    rx_byte  = 8'h00;

    do_reset();
    chk("rst_baud", 32'(bus.uart_baud), 32'hB);
    chk("rst_eight", 32'(bus.uart_eight), 0);
    chk("rst_p_en", 32'(bus.uart_p_en), 0);
    chk("rst_ohel", 32'(bus.uart_ohel), 0);
    chk("rst_write", 32'(bus.uart_write), 0);
    chk("rst_read", 32'(bus.uart_read), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data", 32'(bus.rx_data), 0);

    // Single A request: write and ready three cycles after the request is seen.
    stat_val = 8'h01;
    bus.req_a_data  = 8'h6A;
    bus.req_a_valid = 1'b1;
    tx_exp.push_back({1'b0, 8'h6A});
    step();
    chk("t1_stat_read", 32'(bus.uart_read), 32'(RD_STAT));
    chk("t1_cfg_busy", 32'(bus.cfg_ready), 0);
    step();
    chk("t1_decide_write", 32'(bus.uart_write), 0);
    step();
    chk("t1_write", 32'(bus.uart_write), 1);
    chk("t1_port", 32'(bus.uart_out_port), 32'h6A);
    chk("t1_a_ready", 32'(bus.req_a_ready), 1);
    step();
    chk("t1_idle", 32'(bus.cfg_ready), 1);
    chk("t1_drained", tx_exp.size(), 0);

    // Both held valid: grants alternate starting from A.
    do_reset();
    stat_val = 8'h01;
    bus.uart_int = 1'b1;
    hold_mode = 1'b1;
    bus.req_a_data = 8'hA0;
    bus.req_b_data = 8'hB0;
    bus.req_a_valid = 1'b1;
    bus.req_b_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tx_exp.push_back({1'b0, 8'hA0});
      tx_exp.push_back({1'b1, 8'hB0});
    end
    for (int c = 0; c < 80 && tx_exp.size() > 0; c++) step();
    chk("alt_drained", tx_exp.size(), 0);
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;
    bus.uart_int = 1'b0;
    hold_mode = 1'b0;
    repeat (6) step();
    chk("alt_idle", 32'(bus.cfg_ready), 1);

    // Table of TX request patterns, pointer starting at A after reset.
    do_reset();
    stat_val = 8'h01;
    bus.uart_int = 1'b1;
    for (int v = 0; v < 7; v++) begin
      bus.req_a_data  = vecs[v].ad;
      bus.req_b_data  = vecs[v].bd;
      bus.req_a_valid = vecs[v].av;
      bus.req_b_valid = vecs[v].bv;
      tx_exp.push_back({vecs[v].first_b, vecs[v].first_byte});
      if (vecs[v].av && vecs[v].bv) tx_exp.push_back({~vecs[v].first_b, vecs[v].second_byte});
      for (int c = 0; c < 40 && (bus.req_a_valid || bus.req_b_valid); c++) step();
      chk("tbl_done", 32'({bus.req_a_valid, bus.req_b_valid}), 0);
      chk("tbl_drained", tx_exp.size(), 0);
    end
    bus.uart_int = 1'b0;
    repeat (6) step();

    // Interrupt-driven RX with consumer stalling for five cycles.
    do_reset();
    stat_val = 8'h02;
    rx_byte  = 8'h55;
    rx_sb_en = 1'b1;
    bus.uart_int = 1'b1;
    rx_exp.push_back(8'h55);
    step();
    bus.uart_int = 1'b0;
    chk("rx_stat_read", 32'(bus.uart_read), 32'(RD_STAT));
    chk("rx_cfg_busy", 32'(bus.cfg_ready), 0);
    step();
    chk("rx_decide", 32'(bus.uart_read), 0);
    step();
    chk("rx_data_read", 32'(bus.uart_read), 32'(RD_DATA));
    chk("rx_valid_early", 32'(bus.rx_valid), 0);
    stat_val = 8'h00;
    step();
    chk("rx_valid_n4", 32'(bus.rx_valid), 1);
    chk("rx_data_n4", 32'(bus.rx_data), 32'h55);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rx_hold_valid", 32'(bus.rx_valid), 1);
      chk("rx_hold_data", 32'(bus.rx_data), 32'h55);
      chk("rx_hold_noread", 32'(bus.uart_read), 0);
    end
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("rx_repoll", 32'(bus.uart_read), 32'(RD_STAT));
    chk("rx_valid_clr", 32'(bus.rx_valid), 0);
    repeat (2) step();
    chk("rx_idle", 32'(bus.cfg_ready), 1);
    chk("rx_drained", rx_exp.size(), 0);

    // Error status repeated 300 times.
    do_reset();
    stat_val = 8'h16;
    rx_byte  = 8'h3C;
    bus.rx_ready = 1'b1;
    stat_reads = 0;
    bus.uart_int = 1'b1;
    step();
    bus.uart_int = 1'b0;
    for (int c = 0; c < 3000 && stat_reads < 300; c++) begin
      step();
      if (stat_reads == 10 && bus.uart_read == RD_NONE && c < 40) chk("err_cnt_10", 32'(err_cnt), 32'(exp_err10));
    end
    stat_val = 8'h00;
    chk("err_reads", stat_reads, 300);
    repeat (8) step();
    bus.rx_ready = 1'b0;
    chk("err_sat", 32'(err_cnt), 32'(exp_err_sat));
    chk("err_idle", 32'(bus.cfg_ready), 1);

    // Reset while holding a received byte.
    do_reset();
    stat_val = 8'h02;
    rx_byte  = 8'hC3;
    bus.uart_int = 1'b1;
    step();
    bus.uart_int = 1'b0;
    repeat (3) step();
    chk("rh_valid", 32'(bus.rx_valid), 1);
    rst = 1'b1;
    stat_val = 8'h00;
    chk("rh_rst_noread", 32'(bus.uart_read), 0);
    chk("rh_rst_nowrite", 32'(bus.uart_write), 0);
    step();
    rst = 1'b0;
    chk("rh_idle", 32'(bus.cfg_ready), 1);
    chk("rh_rx_valid", 32'(bus.rx_valid), 0);
    chk("rh_rx_data", 32'(bus.rx_data), 0);
    chk("rh_noread", 32'(bus.uart_read), 0);

    // Config load wins over a pending interrupt; writes outside IDLE are dropped.
    bus.cfg_we = 1'b1;
    bus.cfg_wdata = 8'h7C;
    bus.uart_int = 1'b1;
    step();
    bus.cfg_we = 1'b0;
    bus.uart_int = 1'b0;
    chk("cfg_prec_idle", 32'(bus.cfg_ready), 1);
    chk("cfg_baud", 32'(bus.uart_baud), 32'hC);
    chk("cfg_bits", 32'({bus.uart_ohel, bus.uart_p_en, bus.uart_eight}), 32'h7);
    step();
    chk("cfg_then_stat", 32'(bus.uart_read), 32'(RD_STAT));
    bus.cfg_we = 1'b1;
    bus.cfg_wdata = 8'h05;
    step();
    bus.cfg_we = 1'b0;
    chk("cfg_ignored", 32'(bus.uart_baud), 32'hC);
    repeat (3) step();
    chk("cfg_final_idle", 32'(bus.cfg_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
